// File: rtl/scr1_mdu_instr_monitor.sv
// RV32M MULDIV fetch monitor: per-funct3 saturating event counters plus a
// drainable FWFT FIFO of operand records with sticky overflow and drop count.

// One saturating event counter; clear has priority over increment.
module scr1_mdu_evt_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // next count: clear wins, otherwise increment until all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                     cnt_d = '0;
    else if (inc_i && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  // counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

module scr1_mdu_instr_monitor #(
  parameter int         CNT_W   = 16,
  parameter int         DEPTH   = 8,
  parameter logic [7:0] OP_MASK = 8'hF0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     mon_en_i,
  input  logic [1:0]               imem_resp_i,
  input  logic [31:0]              imem_rdata_i,
  input  logic                     cnt_clr_i,
  input  logic [2:0]               cnt_sel_i,
  output logic [CNT_W-1:0]         cnt_val_o,
  output logic                     rec_valid_o,
  input  logic                     rec_ready_i,
  output logic [17:0]              rec_data_o,
  output logic [$clog2(DEPTH):0]   fifo_level_o,
  output logic                     ovf_o,
  output logic [CNT_W-1:0]         drop_cnt_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // decode
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic        hit;
  logic [17:0] rec_in;

  assign opcode = imem_rdata_i[6:0];
  assign funct3 = imem_rdata_i[14:12];
  assign funct7 = imem_rdata_i[31:25];
  assign hit    = mon_en_i && (imem_resp_i == 2'b01) && (opcode == 7'b0110011) &&
                  (funct7 == 7'b0000001) && OP_MASK[funct3];
  assign rec_in = {funct3, imem_rdata_i[11:7], imem_rdata_i[19:15], imem_rdata_i[24:20]};

  // per-funct3 counters
  logic [7:0][CNT_W-1:0] cnt_all;

  for (genvar g = 0; g < 8; g++) begin : g_cnt
    scr1_mdu_evt_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (cnt_clr_i),
      .inc_i (hit && (funct3 == 3'(g))),
      .cnt_o (cnt_all[g])
    );
  end

  assign cnt_val_o = cnt_all[cnt_sel_i];

  // record FIFO
  logic [17:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             full, empty, pop, push, drop;

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign pop   = !empty && rec_ready_i;
  // a pop in the same cycle frees the slot the new record needs
  assign push  = hit && (!full || pop);
  assign drop  = hit && full && !pop;

  // level, overflow flag and drop counter next-state
  always_comb begin
    level_d = level_q + LVL_W'(push) - LVL_W'(pop);
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    if (cnt_clr_i) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != '1) drop_d = drop_q + 1'b1;
    end
  end

  // pointer, level and overflow state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  // storage; contents are don't-care until the level covers them
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= rec_in;
  end

  assign rec_valid_o  = !empty;
  assign rec_data_o   = empty ? 18'h0 : mem_q[rd_ptr_q];
  assign fifo_level_o = level_q;
  assign ovf_o        = ovf_q;
  assign drop_cnt_o   = drop_q;
endmodule

// File: tb/tb_scr1_mdu_instr_monitor.sv
// Bench for scr1_mdu_instr_monitor: directed vector table, hand sequences for
// overflow/saturation/reset corners, then random traffic against a queue model.
module tb_scr1_mdu_instr_monitor;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst, mon_en, cnt_clr, rec_ready;
  logic [1:0]  imem_resp;
  logic [31:0] imem_rdata;
  logic [2:0]  cnt_sel;

  logic [15:0] cnt_val, drop_cnt;
  logic        rec_valid, ovf;
  logic [17:0] rec_data;
  logic [3:0]  fifo_level;

  logic [1:0]  cnt_val2, drop_cnt2;
  logic        rec_valid2, ovf2;
  logic [17:0] rec_data2;
  logic [3:0]  fifo_level2;

  always #5 clk = ~clk;

  scr1_mdu_instr_monitor u_dut (
    .clk_i(clk), .rst_i(rst), .mon_en_i(mon_en), .imem_resp_i(imem_resp),
    .imem_rdata_i(imem_rdata), .cnt_clr_i(cnt_clr), .cnt_sel_i(cnt_sel),
    .cnt_val_o(cnt_val), .rec_valid_o(rec_valid), .rec_ready_i(rec_ready),
    .rec_data_o(rec_data), .fifo_level_o(fifo_level), .ovf_o(ovf),
    .drop_cnt_o(drop_cnt)
  );

  scr1_mdu_instr_monitor #(.CNT_W(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .mon_en_i(mon_en), .imem_resp_i(imem_resp),
    .imem_rdata_i(imem_rdata), .cnt_clr_i(cnt_clr), .cnt_sel_i(cnt_sel),
    .cnt_val_o(cnt_val2), .rec_valid_o(rec_valid2), .rec_ready_i(rec_ready),
    .rec_data_o(rec_data2), .fifo_level_o(fifo_level2), .ovf_o(ovf2),
    .drop_cnt_o(drop_cnt2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: queue of records, integer counters
  logic [7:0]  mask = 8'hF0;
  logic [17:0] q[$];
  int          cnt[8], cnt2[8];
  int          mdrop, mdrop2;
  bit          movf;

  function automatic logic [31:0] mkw(input logic [2:0] f3, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0000001, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  task automatic model_step();
    logic [2:0] f3;
    bit hit, dropped;
    f3  = imem_rdata[14:12];
    hit = mon_en && imem_resp == 2'b01 && imem_rdata[6:0] == 7'h33 &&
          imem_rdata[31:25] == 7'h01 && mask[f3];
    if (rst) begin
      q.delete();
      for (int i = 0; i < 8; i++) begin cnt[i] = 0; cnt2[i] = 0; end
      mdrop = 0; mdrop2 = 0; movf = 0;
      return;
    end
    if (q.size() > 0 && rec_ready) void'(q.pop_front());
    dropped = 0;
    if (hit) begin
      if (q.size() < DEPTH)
        q.push_back({f3, imem_rdata[11:7], imem_rdata[19:15], imem_rdata[24:20]});
      else
        dropped = 1;
    end
    if (cnt_clr) begin
      for (int i = 0; i < 8; i++) begin cnt[i] = 0; cnt2[i] = 0; end
      mdrop = 0; mdrop2 = 0; movf = 0;
    end else begin
      if (hit) begin
        if (cnt[f3] < 65535) cnt[f3]++;
        if (cnt2[f3] < 3)    cnt2[f3]++;
      end
      if (dropped) begin
        movf = 1;
        if (mdrop < 65535) mdrop++;
        if (mdrop2 < 3)    mdrop2++;
      end
    end
  endtask

  task automatic model_check();
    logic [17:0] head;
    head = (q.size() > 0) ? q[0] : 18'h0;
    chk("level",     32'(fifo_level), 32'(q.size()));
    chk("valid",     32'(rec_valid),  32'(q.size() > 0));
    chk("data",      32'(rec_data),   32'(head));
    chk("ovf",       32'(ovf),        32'(movf));
    chk("drop_cnt",  32'(drop_cnt),   32'(mdrop));
    chk("cnt_val",   32'(cnt_val),    32'(cnt[cnt_sel]));
    chk("level2",    32'(fifo_level2), 32'(q.size()));
    chk("valid2",    32'(rec_valid2), 32'(q.size() > 0));
    chk("data2",     32'(rec_data2),  32'(head));
    chk("ovf2",      32'(ovf2),       32'(movf));
    chk("drop_cnt2", 32'(drop_cnt2),  32'(mdrop2));
    chk("cnt_val2",  32'(cnt_val2),   32'(cnt2[cnt_sel]));
  endtask

  // one clock: model consumes the inputs in force at the edge, then compare
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    model_check();
  endtask

  task automatic idle();
    rst = 0; mon_en = 1; imem_resp = 2'b00; imem_rdata = 32'h0; cnt_clr = 0;
  endtask

  task automatic hit_word(input logic [31:0] w);
    mon_en = 1; imem_resp = 2'b01; imem_rdata = w;
  endtask

  typedef struct {
    logic        rst, en;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic        clr;
    logic [2:0]  sel;
    logic        rdy;
    logic        ev;
    logic [3:0]  elvl;
    logic [17:0] edata;
    logic [15:0] ecnt;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [17:0] exp_rec;
    //         rst en resp   rdata         clr sel rdy  ev lvl data      cnt
    tbl[0] = '{1, 1, 2'b00, 32'h0,        0, 3'd4, 0,  0, 0, 18'h0,     16'd0};
    tbl[1] = '{0, 1, 2'b01, 32'h027302B3, 0, 3'd0, 0,  0, 0, 18'h0,     16'd0};
    tbl[2] = '{0, 1, 2'b00, 32'h0220C1B3, 0, 3'd4, 0,  0, 0, 18'h0,     16'd0};
    tbl[3] = '{0, 0, 2'b01, 32'h0220C1B3, 0, 3'd4, 0,  0, 0, 18'h0,     16'd0};
    tbl[4] = '{0, 1, 2'b10, 32'h0220C1B3, 0, 3'd4, 0,  0, 0, 18'h0,     16'd0};
    tbl[5] = '{0, 1, 2'b01, 32'h0220C1B3, 0, 3'd4, 0,  1, 1, 18'h20C22, 16'd1};
    tbl[6] = '{0, 1, 2'b00, 32'h0,        0, 3'd4, 1,  0, 0, 18'h0,     16'd1};
    tbl[7] = '{0, 1, 2'b00, 32'h0,        1, 3'd4, 1,  0, 0, 18'h0,     16'd0};
    tbl[8] = '{0, 1, 2'b01, 32'h027302B3, 0, 3'd0, 1,  0, 0, 18'h0,     16'd0};

    rst = 1; mon_en = 0; imem_resp = 0; imem_rdata = 0; cnt_clr = 0;
    cnt_sel = 0; rec_ready = 0;
    @(posedge clk); #1;

    // directed vectors
    for (int i = 0; i < 9; i++) begin
      rst = tbl[i].rst; mon_en = tbl[i].en; imem_resp = tbl[i].resp;
      imem_rdata = tbl[i].rdata; cnt_clr = tbl[i].clr; cnt_sel = tbl[i].sel;
      rec_ready = tbl[i].rdy;
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(rec_valid),  32'(tbl[i].ev));
      chk($sformatf("vec%0d_level", i), 32'(fifo_level), 32'(tbl[i].elvl));
      chk($sformatf("vec%0d_data", i),  32'(rec_data),   32'(tbl[i].edata));
      chk($sformatf("vec%0d_cnt", i),   32'(cnt_val),    32'(tbl[i].ecnt));
    end

    // overflow: DEPTH+3 REMU hits with no consumer
    idle(); rst = 1; tick(); idle();
    rec_ready = 0; cnt_sel = 3'd7;
    for (int i = 0; i < DEPTH + 3; i++) begin
      hit_word(mkw(3'b111, 5'(i), 5'(i + 1), 5'(i + 2)));
      tick();
    end
    idle();
    tick();
    chk("ovf_level", 32'(fifo_level), DEPTH);
    chk("ovf_flag",  32'(ovf), 1);
    chk("ovf_drops", 32'(drop_cnt), 3);
    chk("ovf_cnt7",  32'(cnt_val), DEPTH + 3);
    rec_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      exp_rec = {3'b111, 5'(i), 5'(i + 1), 5'(i + 2)};
      chk($sformatf("ovf_drain%0d", i), 32'(rec_data), 32'(exp_rec));
      tick();
    end
    chk("ovf_empty", 32'(rec_valid), 0);

    // full FIFO, hit coincides with pop
    idle(); rst = 1; tick(); idle();
    rec_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_word(mkw(3'b110, 5'(i), 5'd1, 5'd2));
      tick();
    end
    hit_word(mkw(3'b101, 5'd31, 5'd30, 5'd29));
    rec_ready = 1;
    tick();
    chk("fp_level", 32'(fifo_level), DEPTH);
    chk("fp_drops", 32'(drop_cnt), 0);
    idle();
    for (int i = 0; i < DEPTH - 1; i++) tick();
    exp_rec = {3'b101, 5'd31, 5'd30, 5'd29};
    chk("fp_last", 32'(rec_data), 32'(exp_rec));
    tick();
    chk("fp_empty", 32'(fifo_level), 0);

    // saturation on the narrow build, then clear against a hit
    idle(); rst = 1; tick(); idle();
    rec_ready = 0; cnt_sel = 3'd5;
    for (int i = 0; i < 5; i++) begin
      hit_word(mkw(3'b101, 5'(i), 5'd3, 5'd4));
      tick();
    end
    chk("sat_cnt2", 32'(cnt_val2), 3);
    chk("sat_cnt",  32'(cnt_val), 5);
    hit_word(mkw(3'b101, 5'd9, 5'd3, 5'd4));
    cnt_clr = 1;
    tick();
    idle();
    chk("clr_cnt2",   32'(cnt_val2), 0);
    chk("clr_cnt",    32'(cnt_val), 0);
    chk("clr_level2", 32'(fifo_level2), 6);

    // reset with records queued and counters nonzero
    idle(); rst = 1; tick(); idle();
    cnt_sel = 3'd6;
    for (int i = 0; i < 4; i++) begin
      hit_word(mkw(3'b110, 5'(i), 5'd5, 5'd6));
      tick();
    end
    chk("pre_rst_cnt", 32'(cnt_val), 4);
    idle(); rst = 1;
    tick();
    rst = 0;
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_valid", 32'(rec_valid), 0);
    chk("rst_data",  32'(rec_data), 0);
    chk("rst_cnt",   32'(cnt_val), 0);
    chk("rst_ovf",   32'(ovf), 0);
    chk("rst_drop",  32'(drop_cnt), 0);
    cnt_sel = 3'd4;
    hit_word(32'h0220C1B3);
    tick();
    idle();
    chk("post_rst_valid", 32'(rec_valid), 1);
    chk("post_rst_data",  32'(rec_data), 32'h20C22);
    chk("post_rst_cnt",   32'(cnt_val), 1);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 199) == 0);
      mon_en    = ($urandom_range(0, 9) != 0);
      imem_resp = ($urandom_range(0, 3) != 0) ? 2'b01 : 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0)
        imem_rdata = mkw(3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'($urandom));
      else
        imem_rdata = $urandom;
      cnt_clr   = ($urandom_range(0, 49) == 0);
      cnt_sel   = 3'($urandom_range(0, 7));
      rec_ready = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/scr1_mdu_instr_monitor.md
# scr1_mdu_instr_monitor

Parametrised monitor on the instruction-memory response path of the AHB router. It decodes every accepted fetch word and detects RV32M MULDIV instructions (opcode 0110011, funct7 0000001) whose funct3 is enabled by a mask. For each enabled operation it keeps a per-funct3 saturating event counter, and it captures operand records into a drainable FIFO with overflow accounting. It is synthesizable and intended for both bench-side coverage and on-chip debug.

## Interface
- CNT_W, 16: width of event counters and drop counter (≥2)
- DEPTH, 8: record FIFO depth, power of two, ≥2
- OP_MASK, 8'hF0: bit i enables funct3 == i (default DIV, DIVU, REM, REMU)

- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- mon_en  in  1  detection enable
- imem_resp  in  2  router response; 2'b01 = valid data
- imem_rdata  in  32  fetched instruction word
- cnt_clr  in  1  clear counters, drop_cnt, ovf
- cnt_sel  in  3  counter index (funct3) for cnt_val
- cnt_val  out  CNT_W  counter[cnt_sel], combinational mux of registers
- rec_valid  out  1  FIFO head valid
- rec_ready  in  1  consumer accepts head
- rec_data  out  18  {funct3[2:0], rd[4:0], rs1[4:0], rs2[4:0]}
- fifo_level  out  $clog2(DEPTH)+1  occupied entries
- ovf  out  1  sticky: a record was dropped
- drop_cnt  out  CNT_W  saturating count of dropped records

## Operation
- hit = mon_en & (imem_resp==2'b01) & opcode==0110011 & funct7==0000001 & OP_MASK[funct3]. Non-matching words, masked funct3 values, and all other resp codes are ignored.
- On hit, counter[funct3] increments and saturates at all-ones. Counters for masked funct3 stay 0.
- On hit, the record is pushed into the FIFO (first-word-fall-through).
- Pop occurs when rec_valid & rec_ready.
- Push when full with no pop in the same cycle: the record is dropped, ovf is set, drop_cnt increments (saturating). FIFO contents are unchanged; the newest record is the one lost.
- Push when full with a pop in the same cycle: the push is accepted, level stays DEPTH, no drop.
- Push and pop when not empty: level unchanged.
- Pop when empty: no effect.
- rec_data = head entry when rec_valid, otherwise 18'h0.
- cnt_clr clears all counters, drop_cnt, and ovf on the next edge. The FIFO is not affected.
- cnt_clr together with a hit: clear wins and the event is not counted. The record is still pushed. If that push is dropped, ovf/drop_cnt are still cleared by cnt_clr.
- Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty are derived from fifo_level.

## Timing
- All state updates on posedge clk.
- Reset values: counters 0, drop_cnt 0, ovf 0, fifo_level 0, rec_valid 0, rec_data 0, cnt_val 0.
- Reset mid-operation discards all FIFO contents and counts on the same edge; outputs return to reset values the following cycle.
- Hit sampled at edge N:
  - counter and fifo_level visible after edge N;
  - rec_valid high from cycle N+1 if the FIFO was empty (latency 1).
- Back-to-back hits every cycle are supported with no bubbles.
- Drain throughput is one record per cycle.
- rec_data and rec_valid are stable while rec_valid & !rec_ready (standard valid/ready: no retraction).
- cnt_val reflects register state in the same cycle cnt_sel changes (no added latency).

## Test plan
- Reset, then a single DIV x3,x1,x2 (imem_rdata 32'h0220C1B3, resp 01). Required: rec_valid=1 next cycle, rec_data=18'h20C22, counter[4]=1 (cnt_sel=4), fifo_level=1. Pop with rec_ready: level returns to 0, rec_data=0.
- MUL x5,x6,x7 (32'h027302B3) and the DIV word above presented with resp=2'b00 or mon_en=0. Required: all counters 0, rec_valid stays 0.
- rec_ready=0 while DEPTH+3 REMU hits are sent (funct3 111). Required:
  - fifo_level=DEPTH, ovf=1, drop_cnt=3, counter[7]=DEPTH+3;
  - draining returns the first DEPTH records in order.
- With the FIFO full, one hit arrives in the same cycle as a pop. Required: level stays DEPTH, drop_cnt unchanged, the new record appears last in the drain.
- CNT_W=2 build, 5 DIVU hits. Required: counter[5]=3 (saturated). Assert cnt_clr in the same cycle as a 6th hit: counter[5]=0 after the edge, and the record is present in the FIFO.
- Assert rst with 4 records queued and counters nonzero. Required: all outputs at reset values, fifo_level=0, and a subsequent hit behaves as in the first test.
